float2int_seq: RTL and testbench
================================

# float2int_seq

Sequential decoder from the 7-bit compact float code (3-bit exponent, 4-bit mantissa) back to an 11-bit unsigned integer. It is the inverse-direction companion of the integer-to-float encoder in the same benchmark family. It sits between a producer of float codes and an integer consumer, with valid/ready handshakes on both sides. Decoding uses one shift per cycle, so latency depends on the exponent.

## Interface
Parameters:
- EXP_W, 3, exponent field width.
- MAN_W, 4, mantissa field width.
- INT_W, MAN_W + 2**EXP_W - 1 (= 11), output integer width. Derived; not overridden.

Ports:
- clk, input, 1, sole clock. All state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_code is valid.
- in_ready, output, 1, block can accept a code.
- in_code, input, EXP_W+MAN_W (7), code word: [6:4] = exponent e, [3:0] = mantissa m.
- out_valid, output, 1, out_int holds a decoded result.
- out_ready, input, 1, consumer accepts out_int.
- out_int, output, INT_W (11), decoded unsigned integer.
- busy, output, 1, high in SHIFT or DONE.

## Operation
- Decode rule:
  - e == 0: value = m (0..15).
  - e >= 1: value = {1'b1, m} << (e-1).
  - Maximum value is 0x7F → 31<<6 = 1984. Result always fits INT_W. No overflow or rounding.
- Registers:
  - state (IDLE, SHIFT, DONE).
  - acc[INT_W-1:0].
  - cnt[EXP_W-1:0].
- IDLE: in_ready=1, out_valid=0. On in_valid & in_ready:
  - e == 0: acc ← zero-extended m. Go to DONE.
  - e == 1: acc ← {1,m}. Go to DONE.
  - e >= 2: acc ← {1,m}, cnt ← e-1. Go to SHIFT.
- SHIFT: each cycle acc ← acc<<1 and cnt ← cnt-1. When cnt == 1 before the decrement, go to DONE. in_ready=0.
- DONE: out_valid=1 and out_int=acc, both held stable. in_ready=0. When out_ready=1, go to IDLE.
- out_int equals acc in all states. Consumers only sample it when out_valid=1.
- in_valid in SHIFT or DONE is ignored. The producer must hold the code until it sees in_ready.
- in_code is sampled only on the accept edge. Later changes do not affect the result in flight.

## Timing
- Reset (rst_n=0, async): state=IDLE, acc=0, cnt=0. Outputs: in_ready=1, out_valid=0, out_int=0, busy=0.
- Deassertion of reset is synchronized externally. The block takes no action on the release edge beyond normal IDLE behaviour.
- Latency from accept edge N to out_valid high:
  - e ≤ 1: valid in the cycle after edge N (1 cycle).
  - e ≥ 2: valid after edge N+e-1 (e cycles).
  - Maximum is 7 cycles.
- Throughput: one code per latency+1 cycles at best. The DONE→IDLE edge is required, so a new code is accepted no earlier than the cycle after the output handshake. There is no overlap.
- Backpressure: out_valid stays high and out_int stays unchanged while out_ready=0, for any duration.
- out_ready high while out_valid is low has no effect.
- Reset asserted mid-SHIFT or in DONE: the in-flight result is discarded immediately and no partial output is presented. After release the block is in IDLE with in_ready=1.

## Test plan
- Reset, then in_code=0x00 with in_valid pulse and out_ready=1 → out_valid one cycle after accept, out_int=0. in_ready back to 1 two cycles after accept.
- in_code=0x09 → 9 with latency 1. in_code=0x10 → 16 with latency 1. in_code=0x35 (e=3, m=5) → 84 with latency 3; cnt observed 2,1.
- in_code=0x7F → 1984 (0x7C0) with latency 7. busy=1 from the cycle after accept until the output handshake.
- Backpressure: in_code=0x2A (→ 52). Hold out_ready=0 for 5 cycles while driving in_valid=1 with 0x7F. out_int stays 52 and in_ready stays 0. After out_ready=1 for one cycle, the 0x7F code is accepted next and yields 1984.
- Reset mid-operation: accept 0x7F, assert rst_n=0 at cycle 3 asynchronously (between edges) → out_valid=0, in_ready=1 immediately. After release, 0x21 → 34 with latency 2.
- Exhaustive sweep of all 128 codes, random out_ready stalls → every out_int matches the decode rule and every latency matches max(1,e). No result is lost or duplicated.

Source files
------------

// File: rtl/float2int_seq.sv
// ============================================================================
// float2int_seq : decodes a {exponent, mantissa} float code into an unsigned
//                 integer, one shift per cycle.       Revision: 1.0
// ============================================================================
`default_nettype none

module float2int_seq #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int INT_W = MAN_W + (1 << EXP_W) - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] in_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       out_int,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [INT_W-1:0]   acc, acc_nx;
  logic [EXP_W-1:0]   cnt, cnt_nx;
  logic [EXP_W-1:0]   exp_f;
  logic [MAN_W-1:0]   man_f;

  assign exp_f = in_code[EXP_W+MAN_W-1:MAN_W];
  assign man_f = in_code[MAN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (exp_f == '0) begin
            acc_nx   = INT_W'(man_f);
            state_nx = DONE;
          end else begin
            // Implicit leading one restored; exponent e needs e-1 further shifts.
            acc_nx = INT_W'({1'b1, man_f});
            if (exp_f == EXP_W'(1)) begin
              state_nx = DONE;
            end else begin
              cnt_nx   = exp_f - EXP_W'(1);
              state_nx = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        acc_nx = acc << 1;
        cnt_nx = cnt - EXP_W'(1);
        if (cnt == EXP_W'(1)) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_int   = acc;

endmodule

`default_nettype wire

// File: tb/tb_float2int_seq.sv
// ============================================================================
// tb_float2int_seq : self-checking bench for float2int_seq.   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_float2int_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_int;
  logic        busy;

  int errors = 0;
  int checks = 0;

  float2int_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] code;
    int         val;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the numeric rule, not from any shift sequence.
  function automatic int ref_val(input logic [6:0] code);
    int e, m;
    e = int'(code[6:4]);
    m = int'(code[3:0]);
    return (e == 0) ? m : (16 + m) * (2 ** (e - 1));
  endfunction

  function automatic int ref_lat(input logic [6:0] code);
    int e;
    e = int'(code[6:4]);
    return (e < 1) ? 1 : e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: present code, count edges from accept to out_valid,
  // apply a random output stall, then complete the handshake.
  task automatic xfer(input logic [6:0] code, input int max_stall,
                      output int val, output int lat);
    int guard;
    int n;
    in_code  = code;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check("accept_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    in_code  = 7'($urandom);
    lat = 1;
    while (!out_valid && lat < 12) begin
      out_ready = 1'($urandom);
      step();
      lat++;
    end
    val = int'(out_int);
    n = $urandom_range(0, max_stall);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      check("stall_valid", int'(out_valid), 1);
      check("stall_hold", int'(out_int), val);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_valid", int'(out_valid), 0);
    check("post_hs_ready", int'(in_ready), 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   val, lat, guard;

    vecs[0] = '{7'h00, 0,    1};
    vecs[1] = '{7'h09, 9,    1};
    vecs[2] = '{7'h10, 16,   1};
    vecs[3] = '{7'h35, 84,   3};
    vecs[4] = '{7'h7F, 1984, 7};
    vecs[5] = '{7'h2A, 52,   2};
    vecs[6] = '{7'h21, 34,   2};

    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_int", int'(out_int), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      xfer(vecs[i].code, 3, val, lat);
      check($sformatf("vec%0d_val", i), val, vecs[i].val);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // 0x35: counter walks 2,1 and busy covers the whole flight.
    in_code = 7'h35; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("c35_cnt2", int'(dut.cnt), 2);
    check("c35_busy", int'(busy), 1);
    step();
    check("c35_cnt1", int'(dut.cnt), 1);
    check("c35_notvalid", int'(out_valid), 0);
    step();
    check("c35_valid", int'(out_valid), 1);
    check("c35_val", int'(out_int), 84);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("c35_idle_busy", int'(busy), 0);

    // Backpressure with a waiting producer that must not be accepted early.
    in_code = 7'h2A; in_valid = 1'b1;
    step();
    in_code = 7'h7F;
    step();
    check("bp_valid", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", int'(out_int), 52);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_released", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    check("bp_next_lat", lat, 7);
    check("bp_next_val", int'(out_int), 1984);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset while shifting.
    in_code = 7'h7F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", int'(out_valid), 0);
    check("ar_in_ready", int'(in_ready), 1);
    check("ar_busy", int'(busy), 0);
    check("ar_out_int", int'(out_int), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    xfer(7'h21, 2, val, lat);
    check("ar_next_val", val, 34);
    check("ar_next_lat", lat, 2);

    // All codes in random order with random stalls.
    begin
      int order[128];
      for (int i = 0; i < 128; i++) order[i] = i;
      for (int i = 127; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 128; i++) begin
        logic [6:0] c;
        c = 7'(order[i]);
        xfer(c, 4, val, lat);
        check($sformatf("sweep_%02h_val", c), val, ref_val(c));
        check($sformatf("sweep_%02h_lat", c), lat, ref_lat(c));
      end
    end

    guard = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
